// File: rtl/oled_spi_rx.sv
// oled_spi_rx: receive-side model of the OLED12864 4-wire SPI write path.
// Oversamples csn/rst/dcn/clk/dat on iclk, deframes mode-0 MSB-first bytes,
// tracks page/column addressing and emits frame-buffer write strobes.
// Non-addressing commands are passed through on ocmd_valid/ocmd_byte.
// Optional feature macro: OLED_RX_FRAME_CNT_EN (frame completion counter).
`timescale 1ns/1ps
module oled_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int COL_MAX     = 127,
  parameter int PAGE_MAX    = 7
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       ioled_csn,
  input  logic       ioled_rst,
  input  logic       ioled_dcn,
  input  logic       ioled_clk,
  input  logic       ioled_dat,
  output logic       owr_en,
  output logic [9:0] owr_addr,
  output logic [7:0] owr_data,
  output logic       ocmd_valid,
  output logic [7:0] ocmd_byte,
  output logic       oerr_abort,
  output logic       oframe_done,
  output logic [7:0] oframe_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] COL_LAST  = 7'(COL_MAX);
  localparam logic [2:0] PAGE_LAST = 3'(PAGE_MAX);

  logic [SYNC_STAGES-1:0] csn_sync, rst_sync, dcn_sync, clk_sync, dat_sync;
  logic csn_d, rst_d, dcn_d, dat_d, clk_prev, rise_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt;
  logic [7:0] sreg;
  logic [2:0] page;
  logic [6:0] col;
  logic       shift_en, byte_done, abort;
  logic [7:0] next_byte;

  // Synchronise the asynchronous serial lines into the iclk domain
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      csn_sync <= '1;
      rst_sync <= '1;
      dcn_sync <= '0;
      clk_sync <= '0;
      dat_sync <= '0;
    end else begin
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], ioled_csn};
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], ioled_rst};
      dcn_sync <= {dcn_sync[SYNC_STAGES-2:0], ioled_dcn};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ioled_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ioled_dat};
    end
  end

  // Register the SPI clock rising edge and keep the other lines aligned with it
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      csn_d    <= 1'b1;
      rst_d    <= 1'b1;
      dcn_d    <= 1'b0;
      dat_d    <= 1'b0;
      clk_prev <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      csn_d    <= csn_sync[SYNC_STAGES-1];
      rst_d    <= rst_sync[SYNC_STAGES-1];
      dcn_d    <= dcn_sync[SYNC_STAGES-1];
      dat_d    <= dat_sync[SYNC_STAGES-1];
      clk_prev <= clk_sync[SYNC_STAGES-1];
      rise_q   <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
    end
  end

  assign next_byte = {sreg[6:0], dat_d};

  // Deframer state register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Deframer next state: display reset dominates, csn high ends a transfer
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    abort     = 1'b0;
    if (!rst_d) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!csn_d) state_d = SHIFT;
        end
        SHIFT: begin
          if (csn_d) begin
            state_d = IDLE;
            abort   = (bit_cnt != 4'd0);
          end else if (rise_q) begin
            shift_en = 1'b1;
            if (bit_cnt == 4'd7) begin
              byte_done = 1'b1;
              state_d   = DONE;
            end
          end
        end
        DONE: begin
          state_d = csn_d ? IDLE : SHIFT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register, addressing state and registered output strobes
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      bit_cnt    <= 4'd0;
      sreg       <= 8'd0;
      page       <= 3'd0;
      col        <= 7'd0;
      owr_en     <= 1'b0;
      owr_addr   <= 10'd0;
      owr_data   <= 8'd0;
      ocmd_valid <= 1'b0;
      ocmd_byte  <= 8'd0;
      oerr_abort <= 1'b0;
    end else begin
      owr_en     <= 1'b0;
      ocmd_valid <= 1'b0;
      if (abort) oerr_abort <= 1'b1;
      if (!rst_d) begin
        bit_cnt <= 4'd0;
        page    <= 3'd0;
        col     <= 7'd0;
      end else begin
        if (state_q != SHIFT) bit_cnt <= 4'd0;
        if (shift_en) begin
          sreg    <= next_byte;
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (byte_done) begin
          if (dcn_d) begin
            owr_en   <= 1'b1;
            owr_addr <= {page, col};
            owr_data <= next_byte;
            col      <= (col == COL_LAST) ? 7'd0 : col + 7'd1;
          end else if (next_byte[7:3] == 5'b10110) begin
            page <= (next_byte[2:0] > PAGE_LAST) ? PAGE_LAST : next_byte[2:0];
          end else if (next_byte[7:4] == 4'h0) begin
            col[3:0] <= next_byte[3:0];
          end else if (next_byte[7:3] == 5'b00010) begin
            col[6:4] <= next_byte[2:0];
          end else begin
            ocmd_valid <= 1'b1;
            ocmd_byte  <= next_byte;
          end
        end
      end
    end
  end

`ifdef OLED_RX_FRAME_CNT_EN
  logic wr_last;
  assign wr_last = byte_done & dcn_d & (page == PAGE_LAST) & (col == COL_LAST);

  // Count writes that land on the final cell of the panel
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oframe_done <= 1'b0;
      oframe_cnt  <= 8'd0;
    end else begin
      oframe_done <= 1'b0;
      if (!rst_d) begin
        oframe_cnt <= 8'd0;
      end else if (wr_last) begin
        oframe_done <= 1'b1;
        oframe_cnt  <= oframe_cnt + 8'd1;
      end
    end
  end
`else
  assign oframe_done = 1'b0;
  assign oframe_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// tb_oled_spi_rx: directed scoreboard bench for oled_spi_rx.
// Optional section enabled by OLED_RX_FRAME_CNT_EN.
`timescale 1ns/1ps
module tb_oled_spi_rx;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  logic       iclk = 1'b0;
  logic       irst_n;
  logic       ioled_csn, ioled_rst, ioled_dcn, ioled_clk, ioled_dat;
  logic       owr_en, ocmd_valid, oerr_abort, oframe_done;
  logic [9:0] owr_addr;
  logic [7:0] owr_data, ocmd_byte, oframe_cnt;

  wr_t        wr_q[$];
  logic [7:0] cmd_q[$];
  logic [2:0] m_page;
  logic [6:0] m_col;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_wr = 0;
  int         n_wr_exp = 0;
  int         n_frames = 0;
  int         edge_seq = 0;
  int         seen_seq = 0;
  int         edge_cnt = 0;

  oled_spi_rx dut (
    .iclk(iclk), .irst_n(irst_n),
    .ioled_csn(ioled_csn), .ioled_rst(ioled_rst), .ioled_dcn(ioled_dcn),
    .ioled_clk(ioled_clk), .ioled_dat(ioled_dat),
    .owr_en(owr_en), .owr_addr(owr_addr), .owr_data(owr_data),
    .ocmd_valid(ocmd_valid), .ocmd_byte(ocmd_byte), .oerr_abort(oerr_abort),
    .oframe_done(oframe_done), .oframe_cnt(oframe_cnt)
  );

  always #5 iclk = ~iclk;

  // Count iclk rising edges since the most recent raw 8th SPI clock edge
  always @(posedge iclk) begin
    if (edge_seq != seen_seq) begin
      seen_seq = edge_seq;
      edge_cnt = 1;
    end else begin
      edge_cnt = edge_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive nbits of one SPI byte; full bytes update the reference model first
  task automatic applyStimulus(input logic dcn, input logic [7:0] value, input int nbits, input int half);
    wr_t w;
    if (nbits == 8) begin
      if (dcn) begin
        w.addr = {m_page, m_col};
        w.data = value;
        w.last = (w.addr == 10'h3FF);
        wr_q.push_back(w);
        n_wr_exp++;
        m_col = (m_col == 7'd127) ? 7'd0 : m_col + 7'd1;
      end else if (value[7:3] == 5'b10110) begin
        m_page = value[2:0];
      end else if (value[7:4] == 4'h0) begin
        m_col[3:0] = value[3:0];
      end else if (value[7:3] == 5'b00010) begin
        m_col[6:4] = value[2:0];
      end else begin
        cmd_q.push_back(value);
      end
    end
    for (int i = 0; i < nbits; i++) begin
      ioled_dcn = dcn;
      ioled_dat = value[7-i];
      repeat (half) @(negedge iclk);
      ioled_clk = 1'b1;
      if (i == 7) edge_seq++;
      repeat (half) @(negedge iclk);
      ioled_clk = 1'b0;
    end
    repeat (half) @(negedge iclk);
  endtask

  task automatic setCsn(input logic v);
    ioled_csn = v;
    repeat (4) @(negedge iclk);
  endtask

  task automatic pulseOledRst();
    ioled_rst = 1'b0;
    repeat (4) @(negedge iclk);
    ioled_rst = 1'b1;
    repeat (6) @(negedge iclk);
    m_page = 3'd0;
    m_col  = 7'd0;
  endtask

  // Scoreboard: compare every strobe against the expected queues
  always @(negedge iclk) begin
    wr_t e;
    logic [7:0] c;
    if (owr_en || ocmd_valid)
      checkOutput("strobe_exclusive", 32'(owr_en & ocmd_valid), 32'd0);
    if (owr_en) begin
      checkOutput("wr_pending", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        checkOutput("wr_addr", 32'(owr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(owr_data), 32'(e.data));
        checkOutput("wr_latency", 32'(edge_cnt), 32'd4);
`ifdef OLED_RX_FRAME_CNT_EN
        checkOutput("frame_done", 32'(oframe_done), 32'(e.last));
`endif
      end
      n_wr++;
    end
    if (ocmd_valid) begin
      checkOutput("cmd_pending", 32'(cmd_q.size() > 0), 32'd1);
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        checkOutput("cmd_byte", 32'(ocmd_byte), 32'(c));
        checkOutput("cmd_latency", 32'(edge_cnt), 32'd4);
      end
    end
    if (oframe_done) n_frames++;
  end

  // Stop a hung run with a reported failure
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    irst_n    = 1'b0;
    ioled_csn = 1'b1;
    ioled_rst = 1'b1;
    ioled_dcn = 1'b0;
    ioled_clk = 1'b0;
    ioled_dat = 1'b0;
    m_page    = 3'd0;
    m_col     = 7'd0;
    repeat (3) @(negedge iclk);
    checkOutput("rst_wr_en", 32'(owr_en), 32'd0);
    checkOutput("rst_cmd_valid", 32'(ocmd_valid), 32'd0);
    checkOutput("rst_abort", 32'(oerr_abort), 32'd0);
    checkOutput("rst_addr", 32'(owr_addr), 32'd0);
    checkOutput("rst_data", 32'(owr_data), 32'd0);
    checkOutput("rst_cmd_byte", 32'(ocmd_byte), 32'd0);
    checkOutput("rst_frame_cnt", 32'(oframe_cnt), 32'd0);
    irst_n = 1'b1;
    repeat (4) @(negedge iclk);

    $display("[TB] addressing commands then one data byte");
    setCsn(1'b0);
    applyStimulus(1'b0, 8'hB3, 8, 4);
    applyStimulus(1'b0, 8'h05, 8, 4);
    applyStimulus(1'b0, 8'h12, 8, 4);
    applyStimulus(1'b1, 8'hA5, 8, 4);
    setCsn(1'b1);

    $display("[TB] latency byte");
    setCsn(1'b0);
    applyStimulus(1'b1, 8'h3C, 8, 4);
    setCsn(1'b1);

    $display("[TB] column wrap");
    setCsn(1'b0);
    applyStimulus(1'b0, 8'hB0, 8, 4);
    applyStimulus(1'b0, 8'h0E, 8, 4);
    applyStimulus(1'b0, 8'h17, 8, 4);
    applyStimulus(1'b1, 8'h11, 8, 4);
    applyStimulus(1'b1, 8'h22, 8, 4);
    applyStimulus(1'b1, 8'h33, 8, 4);

    $display("[TB] pass-through command");
    applyStimulus(1'b0, 8'hAF, 8, 4);
    applyStimulus(1'b1, 8'h44, 8, 4);
    setCsn(1'b1);

    $display("[TB] aborted partial byte");
    setCsn(1'b0);
    applyStimulus(1'b1, 8'hFF, 5, 4);
    setCsn(1'b1);
    repeat (4) @(negedge iclk);
    checkOutput("abort_set", 32'(oerr_abort), 32'd1);
    setCsn(1'b0);
    applyStimulus(1'b1, 8'h81, 8, 4);
    setCsn(1'b1);
    checkOutput("abort_sticky", 32'(oerr_abort), 32'd1);

    $display("[TB] display reset clears addressing");
    pulseOledRst();
    setCsn(1'b0);
    applyStimulus(1'b1, 8'h55, 8, 4);
    setCsn(1'b1);
    checkOutput("abort_kept_by_oled_rst", 32'(oerr_abort), 32'd1);

`ifdef OLED_RX_FRAME_CNT_EN
    $display("[TB] full frame");
    setCsn(1'b0);
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1'b0, 8'hB0 | 8'(p), 8, 2);
      applyStimulus(1'b0, 8'h00, 8, 2);
      applyStimulus(1'b0, 8'h10, 8, 2);
      for (int k = 0; k < 128; k++) applyStimulus(1'b1, 8'(k + p), 8, 2);
    end
    setCsn(1'b1);
    repeat (4) @(negedge iclk);
    checkOutput("frame_pulses", 32'(n_frames), 32'd1);
    checkOutput("frame_cnt", 32'(oframe_cnt), 32'd1);
    pulseOledRst();
    checkOutput("frame_cnt_cleared", 32'(oframe_cnt), 32'd0);
    setCsn(1'b0);
    applyStimulus(1'b1, 8'h99, 8, 2);
    setCsn(1'b1);
`else
    checkOutput("frame_cnt_tied", 32'(oframe_cnt), 32'd0);
    checkOutput("frame_pulses_none", 32'(n_frames), 32'd0);
`endif

    repeat (20) @(negedge iclk);
    checkOutput("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    checkOutput("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
    checkOutput("wr_count", 32'(n_wr), 32'(n_wr_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
